// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/stall handshake bundle between the pipeline datapath and the stall sequencer.
// The master side raises hazard requests; the slave side returns stall, flush and divider timing.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 id_load_use;
    logic                 ex_div_req;
    logic                 mem_wait;
    logic                 exc_valid;
    logic [4:0]           stall;
    logic                 flush;
    logic                 new_pc_valid;
    logic [31:0]          new_pc;
    logic                 div_start;
    logic                 div_done;
    logic [CNT_WIDTH-1:0] perf_stall_cnt;

    modport master (
        output id_load_use, ex_div_req, mem_wait, exc_valid,
        input  stall, flush, new_pc_valid, new_pc, div_start, div_done, perf_stall_cnt
    );

    modport slave (
        input  id_load_use, ex_div_req, mem_wait, exc_valid,
        output stall, flush, new_pc_valid, new_pc, div_start, div_done, perf_stall_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard/stall sequencer for the 5-stage pipeline: prioritised monotone stall vector,
// exception flush/redirect, EX iterative-divider timing and a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DIV  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_ID   = 5'b00011;
    localparam logic [4:0] STALL_EX   = 5'b00111;
    localparam logic [4:0] STALL_MEM  = 5'b01111;

    // The start cycle is itself the first busy cycle, so the count loaded at start covers the rest.
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

    state_t               state;
    logic [7:0]           div_cnt;
    logic [CNT_WIDTH-1:0] perf_cnt;

    logic [4:0] stall_c;
    logic       flush_c;
    logic       div_start_c;
    logic       div_done_c;
    logic       div_stall_c;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Outputs are forced to their reset values while rst is high, independent of the requests.
    always_comb begin
        stall_c     = STALL_NONE;
        flush_c     = 1'b0;
        div_start_c = 1'b0;
        div_done_c  = 1'b0;
        div_stall_c = 1'b0;
        if (!rst) begin
            if (bus.exc_valid) begin
                flush_c = 1'b1;
            end else begin
                div_start_c = (state == RUN) && bus.ex_div_req;
                div_stall_c = div_start_c || ((state == DIV) && (div_cnt != 8'd0));
                div_done_c  = ((state == DIV) && (div_cnt == 8'd0)) || (state == HOLD);
                if (bus.mem_wait) begin
                    stall_c = STALL_MEM;
                end else if (div_stall_c) begin
                    stall_c = STALL_EX;
                end else if (bus.id_load_use) begin
                    stall_c = STALL_ID;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            div_cnt  <= 8'd0;
            perf_cnt <= '0;
        end else begin
            if (stall_c[0]) begin
                perf_cnt <= sat_inc(perf_cnt);
            end
            if (bus.exc_valid) begin
                state   <= RUN;
                div_cnt <= 8'd0;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.ex_div_req) begin
                            state   <= DIV;
                            div_cnt <= DIV_LOAD;
                        end
                    end
                    DIV: begin
                        if (div_cnt != 8'd0) begin
                            div_cnt <= div_cnt - 8'd1;
                        end else begin
                            // Result is ready; linger in HOLD while a downstream stall keeps EX frozen.
                            state <= stall_c[2] ? HOLD : RUN;
                        end
                    end
                    HOLD: begin
                        if (!stall_c[2]) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state   <= RUN;
                        div_cnt <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign bus.stall          = stall_c;
    assign bus.flush          = flush_c;
    assign bus.new_pc_valid   = flush_c;
    assign bus.new_pc         = EXC_VECTOR;
    assign bus.div_start      = div_start_c;
    assign bus.div_done       = div_done_c;
    assign bus.perf_stall_cnt = perf_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a cycle table of hazard inputs and expected outputs,
// plus hand-written sequences for asynchronous reset mid-divide and counter saturation.
module tb_pipeline_stall_ctrl;

    localparam logic [31:0] EXC = 32'hBFC00380;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipeline_stall_ctrl_if #(.CNT_WIDTH(4)) bus ();

    pipeline_stall_ctrl #(
        .DIV_CYCLES(4),
        .EXC_VECTOR(EXC),
        .CNT_WIDTH (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lu;
        logic       dv;
        logic       mw;
        logic       ex;
        logic [4:0] stall;
        logic       fl;
        logic       ds;
        logic       dd;
        logic [3:0] perf;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic lu, input logic dv, input logic mw, input logic ex,
                                input logic [4:0] st, input logic fl, input logic ds,
                                input logic dd, input logic [3:0] pf);
        vec_t v;
        v.lu = lu; v.dv = dv; v.mw = mw; v.ex = ex;
        v.stall = st; v.fl = fl; v.ds = ds; v.dd = dd; v.perf = pf;
        return v;
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic lu, input logic dv, input logic mw, input logic ex);
        bus.id_load_use = lu;
        bus.ex_div_req  = dv;
        bus.mem_wait    = mw;
        bus.exc_valid   = ex;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle(input logic lu, input logic dv, input logic mw, input logic ex);
        @(posedge clk);
        #1;
        drive(lu, dv, mw, ex);
        #4;
    endtask

    task automatic check_all(input string nm, input int idx, input logic [4:0] st, input logic fl,
                             input logic ds, input logic dd, input logic [3:0] pf);
        cmp({nm, ".stall"}, idx, 32'(bus.stall), 32'(st));
        cmp({nm, ".flush"}, idx, 32'(bus.flush), 32'(fl));
        cmp({nm, ".new_pc_valid"}, idx, 32'(bus.new_pc_valid), 32'(fl));
        cmp({nm, ".div_start"}, idx, 32'(bus.div_start), 32'(ds));
        cmp({nm, ".div_done"}, idx, 32'(bus.div_done), 32'(dd));
        cmp({nm, ".perf"}, idx, 32'(bus.perf_stall_cnt), 32'(pf));
        cmp({nm, ".new_pc"}, idx, bus.new_pc, EXC);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        //                 lu dv mw ex   stall     fl ds dd perf
        // load-use for one cycle
        vecs[0]  = mk(1, 0, 0, 0, 5'b00011, 0, 0, 0, 4'd0);
        vecs[1]  = mk(0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'd1);
        // divide, DIV_CYCLES=4: start cycle 2, done cycle 5
        vecs[2]  = mk(0, 1, 0, 0, 5'b00111, 0, 1, 0, 4'd1);
        vecs[3]  = mk(0, 1, 0, 0, 5'b00111, 0, 0, 0, 4'd2);
        vecs[4]  = mk(0, 1, 0, 0, 5'b00111, 0, 0, 0, 4'd3);
        vecs[5]  = mk(0, 1, 0, 0, 5'b00000, 0, 0, 1, 4'd4);
        vecs[6]  = mk(0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'd4);
        // divide with mem_wait on the done cycle and the one after: HOLD keeps div_done
        vecs[7]  = mk(0, 1, 0, 0, 5'b00111, 0, 1, 0, 4'd4);
        vecs[8]  = mk(0, 1, 0, 0, 5'b00111, 0, 0, 0, 4'd5);
        vecs[9]  = mk(0, 1, 0, 0, 5'b00111, 0, 0, 0, 4'd6);
        vecs[10] = mk(0, 1, 1, 0, 5'b01111, 0, 0, 1, 4'd7);
        vecs[11] = mk(0, 1, 1, 0, 5'b01111, 0, 0, 1, 4'd8);
        vecs[12] = mk(0, 1, 0, 0, 5'b00000, 0, 0, 1, 4'd9);
        vecs[13] = mk(0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'd9);
        // exception aborts a divide one cycle after start
        vecs[14] = mk(0, 1, 0, 0, 5'b00111, 0, 1, 0, 4'd9);
        vecs[15] = mk(0, 1, 0, 1, 5'b00000, 1, 0, 0, 4'd10);
        vecs[16] = mk(0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'd10);
        // exception beats every other request
        vecs[17] = mk(1, 1, 1, 1, 5'b00000, 1, 0, 0, 4'd10);
        vecs[18] = mk(0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'd10);
        // all requests in RUN: mem_wait wins, divide still starts; then divide beats load-use
        vecs[19] = mk(1, 1, 1, 0, 5'b01111, 0, 1, 0, 4'd10);
        vecs[20] = mk(1, 1, 0, 0, 5'b00111, 0, 0, 0, 4'd11);
        vecs[21] = mk(1, 1, 0, 0, 5'b00111, 0, 0, 0, 4'd12);
        vecs[22] = mk(1, 1, 0, 0, 5'b00011, 0, 0, 1, 4'd13);
        vecs[23] = mk(0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'd14);

        #3;
        check_all("reset", 0, 5'b00000, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            next_cycle(vecs[i].lu, vecs[i].dv, vecs[i].mw, vecs[i].ex);
            check_all("vec", i, vecs[i].stall, vecs[i].fl, vecs[i].ds, vecs[i].dd, vecs[i].perf);
        end

        // asynchronous reset in the middle of a divide, with every request active
        next_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("rstdiv_start", 0, 5'b00111, 1'b0, 1'b1, 1'b0, 4'd14);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check_all("rstdiv_pre", 0, 5'b01111, 1'b0, 1'b0, 1'b0, 4'd15);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check_all("rstdiv_async", 0, 5'b00000, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #4;
        check_all("rstdiv_run", 0, 5'b00000, 1'b0, 1'b0, 1'b0, 4'd0);
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("rstdiv_idle", 0, 5'b00000, 1'b0, 1'b0, 1'b0, 4'd0);

        // 20 stalled cycles into a 4-bit counter: holds at 4'hF, survives a flush
        for (int i = 0; i < 20; i++) begin
            next_cycle(1'b0, 1'b0, 1'b1, 1'b0);
            cmp("sat.stall", i, 32'(bus.stall), 32'(5'b01111));
            cmp("sat.perf", i, 32'(bus.perf_stall_cnt), (i > 15) ? 32'd15 : 32'(i));
        end
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("sat_end", 0, 5'b00000, 1'b0, 1'b0, 1'b0, 4'hF);
        next_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_all("sat_flush", 0, 5'b00000, 1'b1, 1'b0, 1'b0, 4'hF);
        next_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("sat_after", 0, 5'b00000, 1'b0, 1'b0, 1'b0, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
